// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the key-schedule round constant.
package aes_pkg;

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NR     = 10;

    // rcon(0) is never consumed by the schedule; it returns zero.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// One backward step of the AES-128 key schedule: round-i key in, round-(i-1) key out.
module inv_key_step
    import aes_pkg::*;
(
    input  logic [0:KEY_W-1] key_i,
    input  logic [0:3]       idx_i,
    output logic [0:KEY_W-1] prev_key_o
);

    logic [0:WORD_W-1] a, b, c, d;
    logic [0:WORD_W-1] a_n, b_n, c_n, d_n;
    logic [0:WORD_W-1] rot, sub;

    assign {a, b, c, d} = key_i;

    assign d_n = d ^ c;
    assign c_n = c ^ b;
    assign b_n = b ^ a;
    assign rot = {d_n[8:31], d_n[0:7]};

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        sbox u_sbox (
            .din_i  (rot[8*j +: 8]),
            .dout_o (sub[8*j +: 8])
        );
    end

    assign a_n        = a ^ sub ^ {rcon(idx_i), 24'h0};
    assign prev_key_o = {a_n, b_n, c_n, d_n};

endmodule

// File: rtl/sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module sbox (
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);

    // Row r holds S(16r) .. S(16r+15), first entry in the leftmost byte.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout_o = SBOX_TABLE[{din_i, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys NR..0, one per handshake.
module inv_key_schedule #(
    parameter int unsigned NR = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [0:aes_pkg::KEY_W-1] last_key,
    output logic                      busy,
    output logic                      key_valid,
    input  logic                      key_ready,
    output logic [0:aes_pkg::KEY_W-1] round_key,
    output logic [0:3]                round_idx,
    output logic                      done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_EMIT  = 1'b1;
    localparam logic [0:3] LAST_IDX = 4'(NR);

    logic [0:0]                state_q, state_d;
    logic [0:aes_pkg::KEY_W-1] key_q, key_d;
    logic [0:3]                idx_q, idx_d;
    logic                      done_q, done_d;
    logic [0:aes_pkg::KEY_W-1] prev_key;

    inv_key_step u_step (
        .key_i      (key_q),
        .idx_i      (idx_q),
        .prev_key_o (prev_key)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    idx_d   = LAST_IDX;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                if (key_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == ST_EMIT);
    assign key_valid = (state_q == ST_EMIT);
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Randomized self-checking bench: forward key expansion model, DUT must replay it backwards.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0]   sb [256];
    logic [31:0]  w [44];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    inv_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map, independent of any table.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_start(input logic [127:0] key);
        start    = 1'b1;
        last_key = key;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Consumes keys from round 10 down; optional backpressure, busy-restart attempt, early stop, back-to-back reload.
    task automatic drain(input bit bp, input bit inj, input int stop_at, input bit b2b, input logic [127:0] next_key);
        int r = 10;
        bit rdy;
        bit finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (r == stop_at) return;
            check("valid", 128'(key_valid), 128'(1));
            check("busy", 128'(busy), 128'(1));
            check("idx", 128'(round_idx), 128'(r));
            check("key", round_key, exp_rk[r]);
            check("done_low", 128'(done), 128'(0));
            got_rk[r] = round_key;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            key_ready = rdy;
            if (inj && r == 6) begin
                start    = 1'b1;
                last_key = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (rdy) begin
                if (r == 0) finished = 1'b1;
                else r--;
            end
        end
        if (!finished) begin
            check("timeout", 128'(0), 128'(1));
            return;
        end
        key_ready = 1'b0;
        check("done_pulse", 128'(done), 128'(1));
        check("valid_off", 128'(key_valid), 128'(0));
        check("busy_off", 128'(busy), 128'(0));
        if (b2b) begin
            do_start(next_key);
        end else begin
            @(posedge clk); #1;
            check("done_once", 128'(done), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] fips_key;
        logic [127:0] rkey;
        fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rst       = 1'b1;
        start     = 1'b0;
        key_ready = 1'b0;
        last_key  = '0;
        build_sbox();
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(key_valid), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_key", round_key, 128'(0));
        check("rst_idx", 128'(round_idx), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 vector, full throughput
        expand(fips_key);
        do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain(1'b0, 1'b0, -1, 1'b0, '0);
        check("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        check("fips_r0", got_rk[0], fips_key);

        // Backpressure plus an ignored restart during round 6
        do_start(exp_rk[10]);
        drain(1'b1, 1'b1, -1, 1'b0, '0);

        // Asynchronous reset mid-sequence
        do_start(exp_rk[10]);
        drain(1'b0, 1'b0, 4, 1'b0, '0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_valid", 128'(key_valid), 128'(0));
        check("mid_rst_key", round_key, 128'(0));
        check("mid_rst_idx", 128'(round_idx), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_start(exp_rk[10]);
        drain(1'b1, 1'b0, -1, 1'b1, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Back-to-back: all-zero cipher key
        expand('0);
        drain(1'b0, 1'b0, -1, 1'b0, '0);
        check("b2b_r0", got_rk[0], 128'(0));

        // Random keys under random backpressure
        for (int k = 0; k < 4; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            expand(rkey);
            do_start(exp_rk[10]);
            drain(1'b1, 1'b0, -1, 1'b0, '0);
            check("rand_r0", got_rk[0], rkey);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
